traceback_mem_ctrl: RTL and testbench

TRACEBACK_MEM_CTRL -- requirements
Module: traceback_mem_ctrl

---
 rtl/traceback_mem_ctrl_pkg.sv | 15 +
 rtl/traceback_mem_ctrl.sv | 100 ++++++++++
 tb/tb_traceback_mem_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/traceback_mem_ctrl_pkg.sv
// Shared sizing and state encoding for the traceback row-buffer controller.
package traceback_mem_ctrl_pkg;
  localparam int DIRECTION_WIDTH = 2;
  localparam int N               = 64;
  localparam int ADDRESS_WIDTH   = 10;
  localparam int MEM_SIZE        = 1024;
  localparam int ROW_W           = DIRECTION_WIDTH * N;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/traceback_mem_ctrl.sv
// Buffers direction rows from the systolic array into row memory, then
// replays them newest-first to the traceback engine.
module traceback_mem_ctrl
  import traceback_mem_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [ROW_W-1:0]         in_dir,
  output logic                     in_ready,
  output logic                     mem_wen,
  output logic                     mem_ren,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic [ADDRESS_WIDTH-1:0] mem_raddr,
  output logic [ROW_W-1:0]         mem_d,
  input  logic [ROW_W-1:0]         mem_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROW_W-1:0]         out_dir,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  state_t                   r_state, w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_wcnt, r_raddr;
  logic                     r_rd_pend;   // rows still to be read back
  logic                     r_tail;      // row held on out_dir is address 0
  logic                     r_out_valid, r_overflow;
  logic                     w_accept, w_full, w_fill_end, w_ren, w_xfer;

  always_comb begin
    w_accept   = (r_state == S_FILL) && in_valid;
    w_full     = (r_wcnt == ADDRESS_WIDTH'(MEM_SIZE - 1));
    w_fill_end = w_accept && (in_last || w_full);
    w_ren      = (r_state == S_DRAIN) && r_rd_pend && (!r_out_valid || out_ready);
    w_xfer     = r_out_valid && out_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FILL;
      S_FILL:  if (w_fill_end) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_xfer && r_tail && !r_rd_pend) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_raddr     <= '0;
      r_rd_pend   <= 1'b0;
      r_tail      <= 1'b0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_wcnt     <= '0;
        r_overflow <= 1'b0;
      end
      if (w_accept) r_wcnt <= r_wcnt + ADDRESS_WIDTH'(1);
      // Readback starts from the row just written, whether it ended the
      // matrix or filled the last memory slot.
      if (w_fill_end) begin
        r_raddr   <= r_wcnt;
        r_rd_pend <= 1'b1;
        if (!in_last) r_overflow <= 1'b1;
      end
      if (w_ren) begin
        r_tail <= (r_raddr == '0);
        if (r_raddr == '0) r_rd_pend <= 1'b0;
        else               r_raddr   <= r_raddr - ADDRESS_WIDTH'(1);
      end
      if (w_ren)       r_out_valid <= 1'b1;
      else if (w_xfer) r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    in_ready  = (r_state == S_FILL);
    mem_wen   = w_accept;
    mem_waddr = r_wcnt;
    mem_d     = (r_state == S_FILL) ? in_dir : '0;
    mem_ren   = w_ren;
    mem_raddr = r_raddr;
    out_valid = r_out_valid;
    out_dir   = mem_q;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    overflow  = r_overflow;
  end

endmodule

// File: tb/tb_traceback_mem_ctrl.sv
// Directed bench for traceback_mem_ctrl with a behavioural row memory.
module tb_traceback_mem_ctrl;
  import traceback_mem_ctrl_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst, start, in_valid, in_last, in_ready;
  logic [ROW_W-1:0]         in_dir, mem_d, mem_q, out_dir;
  logic                     mem_wen, mem_ren, out_valid, out_ready, busy, done, overflow;
  logic [ADDRESS_WIDTH-1:0] mem_waddr, mem_raddr;

  int n_chk = 0;
  int n_pass = 0;

  traceback_mem_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .in_dir(in_dir), .in_ready(in_ready), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_d(mem_d), .mem_q(mem_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [ROW_W-1:0] mem [MEM_SIZE];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_d;
    if (mem_ren) mem_q <= mem[mem_raddr];
  end

  function automatic logic [ROW_W-1:0] pat(int k);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < ROW_W / 32; j++)
      r[j*32 +: 32] = 32'(k) ^ (32'(j) << 24) ^ 32'h5A5A_0000;
    return r;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic start, iv, il; int din; logic ordy;
    logic e_busy, e_rdy, e_wen; int e_waddr; logic e_ren; int e_raddr;
    logic e_ov; int e_odk; logic e_done;
  } vec_t;

  function automatic vec_t mk(logic st, logic iv, logic il, int din, logic ordy,
                              logic b, logic rdy, logic wen, int wa, logic ren,
                              int ra, logic ov, int odk, logic dn);
    vec_t v;
    v.start = st; v.iv = iv; v.il = il; v.din = din; v.ordy = ordy;
    v.e_busy = b; v.e_rdy = rdy; v.e_wen = wen; v.e_waddr = wa; v.e_ren = ren;
    v.e_raddr = ra; v.e_ov = ov; v.e_odk = odk; v.e_done = dn;
    return v;
  endfunction

  task automatic fill(string tag, int k0, int n, bit last, bit hold_start);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = hold_start; in_valid = 1'b1; in_last = last && (i == n - 1);
      in_dir = pat(k0 + i);
      #1;
      chk($sformatf("%s_wr%0d", tag, i), {in_ready, mem_wen, mem_waddr, mem_d},
          {1'b1, 1'b1, ADDRESS_WIDTH'(i), pat(k0 + i)});
      if (i == 0 || i == MEM_SIZE - 1) chk($sformatf("%s_ovf%0d", tag, i), overflow, 0);
    end
  endtask

  task automatic drain(string tag, int kfirst, int n, bit toggle, bit hold_start,
                       int stop_after, output int nreads, output int first_raddr);
    int got = 0;
    bit stalled = 0, seen_done = 0;
    logic [ROW_W-1:0] held = '0;
    nreads = 0; first_raddr = -1;
    for (int c = 0; c < n * 4 + 20; c++) begin
      @(negedge clk);
      start = hold_start; in_valid = 1'b0; in_last = 1'b0;
      out_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      #1;
      if (mem_ren) begin
        if (nreads == 0) first_raddr = int'(mem_raddr);
        nreads++;
      end
      if (stalled && out_valid) chk({tag, "_hold"}, out_dir, held);
      stalled = 0;
      if (out_valid && !out_ready) begin
        chk({tag, "_stall_ren"}, mem_ren, 0);
        held = out_dir; stalled = 1;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("%s_out%0d", tag, got), out_dir, pat(kfirst - got));
        got++;
        if (got == stop_after) return;
      end
      if (done) begin
        seen_done = 1; start = 1'b0;
        break;
      end
    end
    chk({tag, "_count"}, got, n);
    chk({tag, "_done"}, seen_done, 1);
    @(negedge clk);
    start = 1'b0; #1;
    chk({tag, "_idle"}, {busy, done, out_valid}, 3'b000);
  endtask

  vec_t tv[12];
  int nr, fr;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_dir = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", {busy, done, overflow, out_valid, in_ready, mem_wen, mem_ren, mem_waddr, mem_raddr, mem_d},
        '0);
    rst = 1'b0;

    // Four rows A..D (keys 1..4), continuous out_ready.
    //          st iv il din ordy  busy rdy wen wa  ren ra  ov  odk done
    tv[0]  = mk(1, 0, 0, -1, 1,    0,   0,  0,  0,  0,  0,  0,  -1, 0);
    tv[1]  = mk(0, 1, 0,  1, 1,    1,   1,  1,  0,  0,  0,  0,  -1, 0);
    tv[2]  = mk(0, 1, 0,  2, 1,    1,   1,  1,  1,  0,  0,  0,  -1, 0);
    tv[3]  = mk(0, 1, 0,  3, 1,    1,   1,  1,  2,  0,  0,  0,  -1, 0);
    tv[4]  = mk(0, 1, 1,  4, 1,    1,   1,  1,  3,  0,  0,  0,  -1, 0);
    tv[5]  = mk(0, 0, 0, -1, 1,    1,   0,  0,  0,  1,  3,  0,  -1, 0);
    tv[6]  = mk(0, 0, 0, -1, 1,    1,   0,  0,  0,  1,  2,  1,   4, 0);
    tv[7]  = mk(0, 0, 0, -1, 1,    1,   0,  0,  0,  1,  1,  1,   3, 0);
    tv[8]  = mk(0, 0, 0, -1, 1,    1,   0,  0,  0,  1,  0,  1,   2, 0);
    tv[9]  = mk(0, 0, 0, -1, 1,    1,   0,  0,  0,  0,  0,  1,   1, 0);
    tv[10] = mk(0, 0, 0, -1, 1,    1,   0,  0,  0,  0,  0,  0,  -1, 1);
    tv[11] = mk(0, 0, 0, -1, 1,    0,   0,  0,  0,  0,  0,  0,  -1, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = tv[i].start; in_valid = tv[i].iv; in_last = tv[i].il;
      in_dir = (tv[i].din >= 0) ? pat(tv[i].din) : '0;
      out_ready = tv[i].ordy;
      #1;
      chk($sformatf("vec%0d", i),
          {busy, in_ready, mem_wen, mem_ren, out_valid, done,
           mem_wen ? mem_waddr : '0, mem_ren ? mem_raddr : '0},
          {tv[i].e_busy, tv[i].e_rdy, tv[i].e_wen, tv[i].e_ren, tv[i].e_ov, tv[i].e_done,
           ADDRESS_WIDTH'(tv[i].e_waddr), ADDRESS_WIDTH'(tv[i].e_raddr)});
      if (tv[i].e_odk >= 0) chk($sformatf("vec%0d_dir", i), out_dir, pat(tv[i].e_odk));
    end

    // Three rows with a stalling consumer.
    fill("tog", 11, 3, 1, 0);
    drain("tog", 13, 3, 1, 0, 0, nr, fr);
    chk("tog_reads", nr, 3);

    // Single-row matrix.
    fill("one", 50, 1, 1, 0);
    drain("one", 50, 1, 0, 0, 0, nr, fr);
    chk("one_reads", nr, 1);
    chk("one_raddr", fr, 0);

    // Overflow: MEM_SIZE rows without in_last, then two rows that must be refused.
    fill("ovf", 100, MEM_SIZE, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_dir = pat(9999); out_ready = 1'b0;
      #1;
      chk($sformatf("ovf_extra%0d", i),
          {in_ready, mem_wen, mem_ren, overflow, mem_ren ? mem_raddr : '0},
          {1'b0, 1'b0, (i == 0), 1'b1, (i == 0) ? ADDRESS_WIDTH'(MEM_SIZE - 1) : '0});
    end
    drain("ovf", 100 + MEM_SIZE - 1, MEM_SIZE, 0, 0, 0, nr, fr);
    chk("ovf_reads", nr, MEM_SIZE - 1);

    // Reset in the middle of a drain, then a fresh two-row matrix.
    fill("rst", 21, 4, 1, 0);
    drain("rst", 24, 4, 0, 0, 2, nr, fr);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid", {busy, done, overflow, out_valid, mem_wen, mem_ren, mem_waddr, mem_raddr}, '0);
    rst = 1'b0;
    fill("post", 31, 2, 1, 0);
    drain("post", 32, 2, 0, 0, 0, nr, fr);

    // start held high through fill and drain must not disturb anything.
    fill("hold", 41, 3, 1, 1);
    drain("hold", 43, 3, 0, 1, 0, nr, fr);
    chk("hold_reads", nr, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
